// File: rtl/bell_arbiter_57.sv
// bell_arbiter_57: ownership arbiter for the single piezo buzzer pin.
// Sources by priority: organ > alarm > chime > key-click beep.
// The alarm timeout and the chime beep/gap cadence run from the beat strobe tick_57.
// Optional key-click beep: compiled in only when BELL_KEYBEEP_EN is defined.
module bell_arbiter_57 #(
  parameter logic [7:0]  ALARM_BEATS = 8'd120,
  parameter logic [2:0]  CHIME_BEEPS = 3'd4,
  parameter logic [21:0] BEEP_CYCLES = 22'd2_500_000
) (
  input  logic       clk_50m_57,
  input  logic       rst_n_57,
  input  logic       tick_57,
  input  logic       bell_e_57,
  input  logic       organ_req_57,
  input  logic       alarm_req_57,
  input  logic       chime_req_57,
  input  logic       beep_req_57,
  input  logic       alarm_stop_57,
  input  logic       organ_tone_57,
  input  logic       alarm_tone_57,
  input  logic       chime_tone_57,
  input  logic       beep_tone_57,
  output logic       bell_w_57,
  output logic [2:0] owner_57,
  output logic       alarm_active_57,
  output logic       busy_57
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ORGAN     = 3'd1;
  localparam logic [2:0] S_ALARM     = 3'd2;
  localparam logic [2:0] S_CHIME_ON  = 3'd3;
  localparam logic [2:0] S_CHIME_OFF = 3'd5;
`ifdef BELL_KEYBEEP_EN
  localparam logic [2:0] S_BEEP      = 3'd4;
`endif

  logic [2:0] state_q, state_d;
  logic [7:0] alarm_cnt_q, alarm_cnt_d;
  logic       alarm_active_q, alarm_active_d;
  logic [2:0] chime_cnt_q, chime_cnt_d;
  logic [2:0] chime_cnt_inc;
  logic       bell_w_q, bell_w_d;
  logic       tone_sel;
`ifdef BELL_KEYBEEP_EN
  logic [21:0] beep_cnt_q, beep_cnt_d;
  logic        beep_load;
`else
  // Beep inputs are present on the port list but have no function in this build.
  logic unused_beep;
  assign unused_beep = beep_req_57 ^ beep_tone_57;
`endif

  // Alarm period: cancel beats (re)load, load beats a same-cycle tick, ticks count down.
  always_comb begin
    alarm_active_d = alarm_active_q;
    alarm_cnt_d    = alarm_cnt_q;
    if (alarm_stop_57) begin
      alarm_active_d = 1'b0;
      alarm_cnt_d    = 8'd0;
    end else if (alarm_req_57) begin
      alarm_active_d = 1'b1;
      alarm_cnt_d    = ALARM_BEATS;
    end else if (alarm_active_q && tick_57) begin
      if (alarm_cnt_q <= 8'd1) begin
        alarm_cnt_d    = 8'd0;
        alarm_active_d = 1'b0;
      end else begin
        alarm_cnt_d = alarm_cnt_q - 8'd1;
      end
    end
  end

  // Saturating increment of the completed-beep count.
  assign chime_cnt_inc = (chime_cnt_q == 3'd7) ? 3'd7 : chime_cnt_q + 3'd1;

  // Ownership FSM: organ and a running alarm pre-empt everything; chime and beep never resume.
  always_comb begin
    state_d     = state_q;
    chime_cnt_d = chime_cnt_q;
`ifdef BELL_KEYBEEP_EN
    beep_load   = 1'b0;
`endif
    if (organ_req_57) begin
      state_d = S_ORGAN;
    end else if (alarm_active_d) begin
      state_d = S_ALARM;
    end else begin
      case (state_q)
        S_ORGAN, S_ALARM: state_d = S_IDLE;
        S_CHIME_ON: begin
          if (tick_57) state_d = S_CHIME_OFF;
        end
        S_CHIME_OFF: begin
          if (tick_57) begin
            chime_cnt_d = chime_cnt_inc;
            state_d     = (chime_cnt_inc >= CHIME_BEEPS) ? S_IDLE : S_CHIME_ON;
          end
        end
        default: begin
          // IDLE (and BEEP when compiled in): a chime may start, a beep only from IDLE.
          if (chime_req_57 && !alarm_active_q) begin
            state_d     = S_CHIME_ON;
            chime_cnt_d = 3'd0;
          end
`ifdef BELL_KEYBEEP_EN
          else if (state_q == S_IDLE && beep_req_57) begin
            state_d   = S_BEEP;
            beep_load = 1'b1;
          end else if (state_q == S_BEEP && beep_cnt_q <= 22'd1) begin
            state_d = S_IDLE;
          end
`endif
        end
      endcase
    end
  end

`ifdef BELL_KEYBEEP_EN
  // Beep length counter: loaded on entry, counts the cycles left in BEEP, cleared on exit.
  always_comb begin
    beep_cnt_d = beep_cnt_q;
    if (beep_load) begin
      beep_cnt_d = BEEP_CYCLES;
    end else if (state_d != S_BEEP) begin
      beep_cnt_d = 22'd0;
    end else if (beep_cnt_q != 22'd0) begin
      beep_cnt_d = beep_cnt_q - 22'd1;
    end
  end
`endif

  // Tone routed by the current owner; gaps and idle stay silent.
  always_comb begin
    tone_sel = 1'b0;
    case (state_q)
      S_ORGAN:    tone_sel = organ_tone_57;
      S_ALARM:    tone_sel = alarm_tone_57;
      S_CHIME_ON: tone_sel = chime_tone_57;
`ifdef BELL_KEYBEEP_EN
      S_BEEP:     tone_sel = beep_tone_57;
`endif
      default:    tone_sel = 1'b0;
    endcase
    bell_w_d = bell_e_57 & tone_sel;
  end

  // State, timers and the registered buzzer pin.
  always_ff @(posedge clk_50m_57 or negedge rst_n_57) begin
    if (!rst_n_57) begin
      state_q        <= S_IDLE;
      alarm_cnt_q    <= 8'd0;
      alarm_active_q <= 1'b0;
      chime_cnt_q    <= 3'd0;
      bell_w_q       <= 1'b0;
`ifdef BELL_KEYBEEP_EN
      beep_cnt_q     <= 22'd0;
`endif
    end else begin
      state_q        <= state_d;
      alarm_cnt_q    <= alarm_cnt_d;
      alarm_active_q <= alarm_active_d;
      chime_cnt_q    <= chime_cnt_d;
      bell_w_q       <= bell_w_d;
`ifdef BELL_KEYBEEP_EN
      beep_cnt_q     <= beep_cnt_d;
`endif
    end
  end

  // Owner code: both chime phases report the chime.
  always_comb begin
    case (state_q)
      S_ORGAN:     owner_57 = 3'd1;
      S_ALARM:     owner_57 = 3'd2;
      S_CHIME_ON:  owner_57 = 3'd3;
      S_CHIME_OFF: owner_57 = 3'd3;
`ifdef BELL_KEYBEEP_EN
      S_BEEP:      owner_57 = 3'd4;
`endif
      default:     owner_57 = 3'd0;
    endcase
  end

  assign busy_57         = (owner_57 != 3'd0);
  assign alarm_active_57 = alarm_active_q;
  assign bell_w_57       = bell_w_q;

endmodule

// File: tb/tb_bell_arbiter_57.sv
// tb_bell_arbiter_57: vector table, directed corner sequences and random stimulus
// against a tick/beat-level reference model of the buzzer arbiter.
`timescale 1ns/1ps
module tb_bell_arbiter_57;

  localparam int A_BEATS = 4;
  localparam int C_BEEPS = 2;
  localparam int B_CYC   = 10;
`ifdef BELL_KEYBEEP_EN
  localparam bit BEEP_EN = 1'b1;
`else
  localparam bit BEEP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick = 1'b0, bell_e = 1'b1, organ = 1'b0;
  logic areq = 1'b0, creq = 1'b0, breq = 1'b0, astop = 1'b0;
  logic t_org = 1'b0, t_al = 1'b0, t_ch = 1'b0, t_bp = 1'b0;
  logic       bell_w;
  logic [2:0] owner;
  logic       alarm_active, busy;

  bell_arbiter_57 #(
    .ALARM_BEATS(8'(A_BEATS)),
    .CHIME_BEEPS(3'(C_BEEPS)),
    .BEEP_CYCLES(22'(B_CYC))
  ) dut (
    .clk_50m_57(clk), .rst_n_57(rst_n), .tick_57(tick), .bell_e_57(bell_e),
    .organ_req_57(organ), .alarm_req_57(areq), .chime_req_57(creq),
    .beep_req_57(breq), .alarm_stop_57(astop),
    .organ_tone_57(t_org), .alarm_tone_57(t_al), .chime_tone_57(t_ch),
    .beep_tone_57(t_bp),
    .bell_w_57(bell_w), .owner_57(owner), .alarm_active_57(alarm_active),
    .busy_57(busy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: owner code, beats left, ticks seen by the chime, cycles left of a beep.
  int m_owner = 0;
  int m_alarm_left = 0;
  bit m_alarm_on = 1'b0;
  int m_chime_ticks = 0;
  int m_beep_left = 0;
  bit m_bell = 1'b0;

  typedef struct {
    bit areq, astop, creq, breq, organ, tick, bell_e;
    int exp_owner;
    bit exp_act;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(bit [6:0] in, int o, bit a);
    vec_t v;
    {v.areq, v.astop, v.creq, v.breq, v.organ, v.tick, v.bell_e} = in;
    v.exp_owner = o;
    v.exp_act   = a;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = 0; m_alarm_left = 0; m_alarm_on = 1'b0;
    m_chime_ticks = 0; m_beep_left = 0; m_bell = 1'b0;
  endtask

  // One clock edge of the intended behaviour, from the inputs held across that edge.
  task automatic model_edge();
    bit tone;
    bit on_old;
    on_old = m_alarm_on;
    case (m_owner)
      1: tone = t_org;
      2: tone = t_al;
      3: tone = (m_chime_ticks % 2 == 0) ? t_ch : 1'b0;
      4: tone = t_bp;
      default: tone = 1'b0;
    endcase
    m_bell = bell_e & tone;

    if (astop) begin
      m_alarm_on = 1'b0; m_alarm_left = 0;
    end else if (areq) begin
      m_alarm_on = 1'b1; m_alarm_left = A_BEATS;
    end else if (m_alarm_on && tick) begin
      m_alarm_left--;
      if (m_alarm_left == 0) m_alarm_on = 1'b0;
    end

    if (organ) m_owner = 1;
    else if (m_alarm_on) m_owner = 2;
    else if (m_owner == 1 || m_owner == 2) m_owner = 0;
    else if (m_owner == 3) begin
      if (tick) begin
        m_chime_ticks++;
        if (m_chime_ticks == 2 * C_BEEPS) m_owner = 0;
      end
    end else if (creq && !on_old) begin
      m_owner = 3; m_chime_ticks = 0;
    end else if (m_owner == 0 && breq && BEEP_EN) begin
      m_owner = 4; m_beep_left = B_CYC;
    end else if (m_owner == 4) begin
      m_beep_left--;
      if (m_beep_left == 0) m_owner = 0;
    end
  endtask

  // Apply the current inputs across one edge, compare against the model, drop the pulses.
  task automatic step();
    {t_org, t_al, t_ch, t_bp} = 4'($urandom);
    @(posedge clk);
    model_edge();
    #1;
    chk("owner", int'(owner), m_owner);
    chk("alarm_active", int'(alarm_active), int'(m_alarm_on));
    chk("busy", int'(busy), int'(m_owner != 0));
    chk("bell_w", int'(bell_w), int'(m_bell));
    areq = 1'b0; creq = 1'b0; breq = 1'b0; astop = 1'b0; tick = 1'b0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_owner", int'(owner), 0);
    chk("rst_active", int'(alarm_active), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_bell", int'(bell_w), 0);
    model_reset();
    areq = 1'b0; creq = 1'b0; breq = 1'b0; astop = 1'b0; tick = 1'b0; organ = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n_beep;

    vecs[0]  = mk(7'b0000001, 0, 1'b0);
    vecs[1]  = mk(7'b1000001, 2, 1'b1);
    vecs[2]  = mk(7'b0000011, 2, 1'b1);
    vecs[3]  = mk(7'b0000011, 2, 1'b1);
    vecs[4]  = mk(7'b0000101, 1, 1'b1);
    vecs[5]  = mk(7'b0000111, 1, 1'b1);
    vecs[6]  = mk(7'b0000001, 2, 1'b1);
    vecs[7]  = mk(7'b0000011, 0, 1'b0);
    vecs[8]  = mk(7'b0010001, 3, 1'b0);
    vecs[9]  = mk(7'b0000011, 3, 1'b0);
    vecs[10] = mk(7'b0000001, 3, 1'b0);
    vecs[11] = mk(7'b0000011, 3, 1'b0);
    vecs[12] = mk(7'b1000001, 2, 1'b1);
    vecs[13] = mk(7'b0100001, 0, 1'b0);
    vecs[14] = mk(7'b1100001, 0, 1'b0);
    vecs[15] = mk(7'b1000011, 2, 1'b1);
    vecs[16] = mk(7'b0000011, 2, 1'b1);
    vecs[17] = mk(7'b0000011, 2, 1'b1);
    vecs[18] = mk(7'b0000011, 2, 1'b1);
    vecs[19] = mk(7'b0000011, 0, 1'b0);
    vecs[20] = mk(7'b0000100, 1, 1'b0);
    vecs[21] = mk(7'b0000110, 1, 1'b0);
    vecs[22] = mk(7'b0000001, 0, 1'b0);
    vecs[23] = mk(7'b0011001, 3, 1'b0);
    vecs[24] = mk(7'b0010001, 3, 1'b0);
    vecs[25] = mk(7'b0001001, 3, 1'b0);
    vecs[26] = mk(7'b0000011, 3, 1'b0);
    vecs[27] = mk(7'b0000011, 3, 1'b0);
    vecs[28] = mk(7'b0000011, 3, 1'b0);
    vecs[29] = mk(7'b0000011, 0, 1'b0);

    do_reset();

    // Directed vector table.
    for (int i = 0; i < 30; i++) begin
      areq = vecs[i].areq; astop = vecs[i].astop; creq = vecs[i].creq;
      breq = vecs[i].breq; organ = vecs[i].organ; tick = vecs[i].tick;
      bell_e = vecs[i].bell_e;
      step();
      chk("tbl_owner", int'(owner), vecs[i].exp_owner);
      chk("tbl_active", int'(alarm_active), int'(vecs[i].exp_act));
      $display("vec %0d: owner=%0d active=%0d bell_w=%0d", i, owner, alarm_active, bell_w);
    end

    // Key beep length from IDLE: exactly BEEP_CYCLES cycles when compiled in, never otherwise.
    bell_e = 1'b1;
    step();
    breq = 1'b1;
    n_beep = 0;
    for (int i = 0; i < B_CYC + 5; i++) begin
      step();
      if (owner == 3'd4) n_beep++;
    end
    chk("beep_len", n_beep, BEEP_EN ? B_CYC : 0);
    $display("beep: owner-4 cycles=%0d", n_beep);

    // Beep aborted by a chime, then the chime aborted by the organ.
    breq = 1'b1; step();
    step();
    creq = 1'b1; step();
    tick = 1'b1; step();
    organ = 1'b1; step();
    organ = 1'b0; step();
    chk("chime_no_resume", int'(owner), 0);
    $display("abort seq: owner=%0d", owner);

    // Reset in the middle of an alarm forgets it.
    areq = 1'b1; step();
    tick = 1'b1; step();
    do_reset();
    step();
    tick = 1'b1; step();
    chk("alarm_forgot", int'(alarm_active), 0);
    $display("reset seq: owner=%0d active=%0d", owner, alarm_active);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if (organ) organ = ($urandom_range(7) != 0);
      else       organ = ($urandom_range(31) == 0);
      tick   = ($urandom_range(3) == 0);
      areq   = ($urandom_range(39) == 0);
      astop  = ($urandom_range(79) == 0);
      creq   = ($urandom_range(11) == 0);
      breq   = ($urandom_range(5) == 0);
      bell_e = ($urandom_range(7) != 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bell_arbiter_57.md
# bell_arbiter_57

Buzzer ownership controller for the clock's single piezo output. It arbitrates four tone sources: live organ keys, the alarm, the hourly chime and an optional key-click beep. Each source gets a fixed priority and a bounded play time. The block runs the alarm timeout and the chime beep/gap cadence from a beat strobe, and drives the one registered buzzer pin.

## Interface
- ALARM_BEATS, 120: alarm length in beats (60 s at 0.5 s/beat), 8-bit counter
- CHIME_BEEPS, 4: beeps per hourly chime, 3-bit counter
- BEEP_CYCLES, 2_500_000: key-beep length in clk cycles (50 ms at 50 MHz), 22-bit counter
- clk_50m_57  in  1  system clock, 50 MHz
- rst_n_57  in  1  reset, asynchronous assert, active-low
- tick_57  in  1  one-cycle beat strobe, synchronous to clk_50m_57
- bell_e_57  in  1  master buzzer enable (hardware switch); level
- organ_req_57  in  1  organ key held; level
- alarm_req_57 / chime_req_57 / beep_req_57  in  1  one-cycle start pulses
- alarm_stop_57  in  1  one-cycle user cancel of the alarm
- organ_tone_57, alarm_tone_57, chime_tone_57, beep_tone_57  in  1  square-wave tone sources
- bell_w_57  out  1  buzzer drive
- owner_57  out  3  current owner: 0 none, 1 organ, 2 alarm, 3 chime, 4 beep
- alarm_active_57  out  1  alarm period running, including while pre-empted
- busy_57  out  1  owner_57 != 0

## Operation
- States: IDLE, ORGAN, ALARM, CHIME_ON, CHIME_OFF, BEEP. owner_57 decodes state (CHIME_ON/OFF both report 3).
- Priority: organ > alarm > chime > beep. Evaluate every cycle.
- Alarm: alarm_req_57 loads alarm_cnt = ALARM_BEATS and sets alarm_active_57. Each tick_57 decrements it while active, in any state. At 0, clear alarm_active_57.
  - alarm_req_57 while active reloads the count.
  - alarm_stop_57 clears alarm_active_57 immediately. Stop wins over a same-cycle request.
- ORGAN is entered whenever organ_req_57=1. On release go to ALARM if alarm_active_57, else IDLE.
  - The alarm keeps timing while pre-empted.
- Chime: chime_req_57 is accepted only if the state is not ORGAN/ALARM and alarm_active_57=0. Otherwise it is dropped.
  - On accept: CHIME_ON, beep_cnt=0. tick_57 toggles ON to OFF.
  - At the OFF tick, increment beep_cnt. If beep_cnt reaches CHIME_BEEPS go to IDLE, else go to CHIME_ON.
  - chime_req_57 during a chime is ignored, with no restart.
  - Pre-emption by organ or alarm aborts the chime. It does not resume.
- Beep: beep_req_57 is accepted only in IDLE. It loads a cycle counter, and BEEP lasts exactly BEEP_CYCLES cycles. Any higher source aborts it.
- bell_w_57 (registered) = bell_e_57 & tone selected by owner. It is 0 in IDLE and CHIME_OFF. bell_e_57=0 silences output but does not affect arbitration or timers.

## Timing
- Reset: state IDLE, all counters 0. bell_w_57=0, owner_57=0, alarm_active_57=0, busy_57=0.
- Reset mid-operation aborts everything and forgets any pending alarm.
- A request sampled at edge N updates owner_57, alarm_active_57 and busy_57 after edge N. bell_w_57 follows owner_57 one cycle later.
- Tone change latency: 1 cycle.
- Organ release: owner changes after the first edge with organ_req_57=0.
- tick_57 coincident with alarm_req_57: load wins, with no decrement that cycle.
- Simultaneous requests in IDLE: the highest priority wins. Lower pulses are dropped, with no queueing.
- Counter widths must cover the parameter maxima. There is no wrap; counters saturate at their terminal value.

## Configuration
- BELL_KEYBEEP_EN defined: BEEP state, beep counter and beep_req_57 handling are compiled in.
- BELL_KEYBEEP_EN undefined: the ports remain, but beep_req_57 and beep_tone_57 are ignored. owner_57 never equals 4, and no beep counter logic is synthesized.

## Test plan
- Reset, then ALARM_BEATS=4. alarm_req_57, then 4 ticks → owner_57=2 and alarm_active_57=1 for 4 ticks, then owner_57=0 and bell_w_57=0.
- Alarm running, organ_req_57 held across 2 ticks then released → owner 2→1→2. alarm_cnt has decreased by 2, and the alarm ends 2 ticks later.
- CHIME_BEEPS=2: chime_req_57 → bell_w_57 toggles with chime_tone_57 for 1 beat, silent 1 beat, repeats once, then owner_57=0 after the 4th tick.
- Chime in progress, then alarm_req_57 → owner_57=2 next cycle and the chime is aborted. After alarm_stop_57, owner_57=0 (no chime resume).
- alarm_req_57 and alarm_stop_57 in the same cycle → alarm_active_57 stays 0. bell_e_57=0 with organ held → owner_57=1, bell_w_57=0.
- With BELL_KEYBEEP_EN and BEEP_CYCLES=10: beep_req_57 in IDLE → owner_57=4 for exactly 10 cycles. The same stimulus without the macro leaves owner_57=0.
